// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the AXI-Stream packet arbiter.
// No logic of its own: the pick is pure combinational arithmetic used by axis_rr_select.
// No backpressure involvement.
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Widest request vector the pick helper can scan.
  localparam int unsigned RR_MAX_REQ = 64;

  // First set bit of req[0 +: n], scanning upward from ptr and wrapping n-1 -> 0.
  // Returns 0 when nothing is set; callers qualify the result with |req.
  function automatic int unsigned rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                          input int unsigned           ptr,
                                          input int unsigned           n);
    int unsigned pick;
    int unsigned k;
    logic        hit;
    pick = 0;
    hit  = 1'b0;
    for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
      k = ptr + i;
      if (k >= n) k = k - n;
      if ((i < n) && !hit && req[k[5:0]]) begin
        pick = k;
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// Bundles the N slave streams and the single master stream of the packet arbiter.
// Pure wiring, zero latency.
// Ready flows from the master sink back to the granted slave only.
interface axis_packet_arbiter_if #(
  parameter int N_SLAVES     = 4,
  parameter int T_DATA_WIDTH = 8,
  parameter int T_ID_WIDTH   = 8,
  parameter int T_USER_WIDTH = 8
);

  // Slave-side streams, slave i occupies [i*W +: W] of each packed field.
  logic [N_SLAVES-1:0]              s_valid;
  logic [N_SLAVES-1:0]              s_ready;
  logic [N_SLAVES*T_DATA_WIDTH-1:0] s_data;
  logic [N_SLAVES*T_ID_WIDTH-1:0]   s_id;
  logic [N_SLAVES*T_USER_WIDTH-1:0] s_user;
  logic [N_SLAVES-1:0]              s_last;

  // Merged master-side stream.
  logic                    m_valid;
  logic                    m_ready;
  logic [T_DATA_WIDTH-1:0] m_data;
  logic [T_ID_WIDTH-1:0]   m_id;
  logic [T_USER_WIDTH-1:0] m_user;
  logic                    m_last;

  // Arbiter side: consumes the slave streams, drives the master stream.
  modport master (
    input  s_valid, s_data, s_id, s_user, s_last, m_ready,
    output s_ready, m_valid, m_data, m_id, m_user, m_last
  );

  // Environment side: sources the slave streams, sinks the master stream.
  modport slave (
    output s_valid, s_data, s_id, s_user, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_id, m_user, m_last
  );

endinterface

// File: rtl/axis_packet_arbiter_rr_select.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
// Zero latency.
// No handshake; the caller decides when the pick is consumed.
module axis_rr_select
  import axis_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  if ((N_REQ < 2) || (N_REQ > RR_MAX_REQ)) begin : g_bad_n
    $error("axis_rr_select: N_REQ must be in [2, RR_MAX_REQ]");
  end

  logic [RR_MAX_REQ-1:0] req_ext;

  // Widen the request vector to the helper's fixed width and pick.
  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    idx                  = IDX_W'(rr_pick(req_ext, 32'(ptr), N_REQ));
    found                = |req;
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter: N AXI-Stream slaves share one master; grant held to tlast.
// 1 cycle arbitration (one bubble per packet), 0 cycle data path from granted slave to master.
// m_ready is routed only to the granted slave; others see ready=0. Macro AXIS_ARB_ID_STAMP_EN stamps m_id.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int N_SLAVES     = 4,
  parameter  int T_DATA_WIDTH = 8,
  parameter  int T_ID_WIDTH   = 8,
  parameter  int T_USER_WIDTH = 8,
  localparam int IDX_W        = $clog2(N_SLAVES)
) (
  input  logic                 clk,
  input  logic                 reset,
  axis_packet_arbiter_if.master bus,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_idx
);

  if (N_SLAVES < 2) begin : g_bad_n
    $error("axis_packet_arbiter: N_SLAVES must be at least 2");
  end

`ifdef AXIS_ARB_ID_STAMP_EN
  if (T_ID_WIDTH < IDX_W) begin : g_bad_id_w
    $error("axis_packet_arbiter: T_ID_WIDTH too narrow to carry the grant index");
  end
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLAVES - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             beat;

  // Round-robin choice among the raw valids, starting at rr_ptr.
  axis_rr_select #(
    .N_REQ (N_SLAVES)
  ) u_rr_select (
    .req   (bus.s_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Route the granted slave to the master and master ready back to that slave only.
  always_comb begin
    bus.m_valid = busy & bus.s_valid[grant_idx];
    bus.m_data  = bus.s_data[grant_idx*T_DATA_WIDTH +: T_DATA_WIDTH];
    bus.m_user  = bus.s_user[grant_idx*T_USER_WIDTH +: T_USER_WIDTH];
    bus.m_last  = bus.s_last[grant_idx];
`ifdef AXIS_ARB_ID_STAMP_EN
    bus.m_id    = T_ID_WIDTH'(grant_idx);
`else
    bus.m_id    = bus.s_id[grant_idx*T_ID_WIDTH +: T_ID_WIDTH];
`endif
    bus.s_ready = '0;
    if (busy) bus.s_ready[grant_idx] = bus.m_ready;
    beat        = bus.m_valid & bus.m_ready;
  end

  // Arbitration FSM: pick in IDLE, hold the grant until the tlast beat is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_idx <= pick_idx;
            busy      <= 1'b1;
            state     <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // Stalls and gaps leave the grant untouched; only a tlast beat releases it.
          if (beat && bus.m_last) begin
            busy   <= 1'b0;
            state  <= ARB_IDLE;
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
